// File: rtl/conv_window_scheduler_pkg.sv
// Shared types and defaults for the 3x3 convolution window scheduler.
// Provides the scheduler state encoding, default geometry constants and
// a helper that gives the number of complete windows in one frame.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int DEF_IMG_W   = 160;
  localparam int DEF_IMG_H   = 120;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_COORD_W = 9;

  // Valid 3x3 windows (no padding): the border ring never becomes a centre.
  function automatic int windows_per_frame(input int img_w, input int img_h);
    return (img_w - 2) * (img_h - 2);
  endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Pixel-stream and window-stream handshake bundle for the scheduler.
// master: the scheduler side; slave: the upstream/convolution-engine side.
interface conv_window_scheduler_if #(
  parameter int ADDR_W  = 16,
  parameter int COORD_W = 9
) ();

  logic               pix_valid;
  logic               pix_ready;
  logic               lb_shift;
  logic [ADDR_W-1:0]  pix_addr;
  logic               win_valid;
  logic               win_ready;
  logic [COORD_W-1:0] win_row;
  logic [COORD_W-1:0] win_col;

  modport master (
    input  pix_valid,
    input  win_ready,
    output pix_ready,
    output lb_shift,
    output pix_addr,
    output win_valid,
    output win_row,
    output win_col
  );

  modport slave (
    output pix_valid,
    output win_ready,
    input  pix_ready,
    input  lb_shift,
    input  pix_addr,
    input  win_valid,
    input  win_row,
    input  win_col
  );

endinterface

// File: rtl/conv_window_scheduler_raster_counter.sv
// Raster position tracker: row/column and linear address of the next pixel.
// Advances once per accepted pixel, wraps the column at IMG_W, and returns
// to the origin after the last pixel so the address never needs a multiplier.
module raster_counter #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int ADDR_W  = 16,
  parameter int COORD_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               advance_i,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               last_o
);

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);

  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               last;

  assign last   = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign last_o = last;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = addr_q;

  // Next position: clear wins, otherwise step in raster order on advance.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clear_i) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (advance_i) begin
      if (last) begin
        row_d  = '0;
        col_d  = '0;
        addr_d = '0;
      end else if (col_q == LAST_COL) begin
        col_d  = '0;
        row_d  = row_q + COORD_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        col_d  = col_q + COORD_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// 3x3 convolution window scheduler for one image frame.
// Accepts raster pixels, drives line-buffer shift/address, presents each
// complete window under valid/ready and pulses done once the last window
// has been consumed.
// Optional build macro CONV_SCHED_STALL_CNT_EN adds the stall_cnt output
// (RUN cycles with a pixel offered but not accepted, saturating).
module conv_window_scheduler
  import conv_sched_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
`ifdef CONV_SCHED_STALL_CNT_EN
  output logic [31:0]             stall_cnt,
`endif
  conv_window_scheduler_if.master bus
);

  sched_state_e       state_q;
  logic               busy_q;
  logic               done_q;
  logic               win_valid_q;
  logic [COORD_W-1:0] win_row_q;
  logic [COORD_W-1:0] win_col_q;

  logic               pix_ready;
  logic               accept;
  logic               win_set;
  logic               win_take;
  logic               frame_start;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic [ADDR_W-1:0]  addr;
  logic               last_pix;

  assign frame_start = (state_q == IDLE) && start;
  // A new pixel may enter only when the window slot is empty or being freed,
  // so a finished window is never overwritten before it is consumed.
  assign pix_ready   = (state_q == RUN) && (!win_valid_q || bus.win_ready);
  assign accept      = bus.pix_valid && pix_ready;
  assign win_take    = win_valid_q && bus.win_ready;
  assign win_set     = accept && (row >= COORD_W'(2)) && (col >= COORD_W'(2));

  raster_counter #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .ADDR_W  (ADDR_W),
    .COORD_W (COORD_W)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (frame_start),
    .advance_i (accept),
    .row_o     (row),
    .col_o     (col),
    .addr_o    (addr),
    .last_o    (last_pix)
  );

  assign bus.pix_ready = pix_ready;
  assign bus.lb_shift  = accept;
  assign bus.pix_addr  = addr;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // Frame sequencing with registered busy/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (accept && last_pix) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // Leave as soon as the final window is gone or being consumed now;
          // no new window can appear in FLUSH.
          if (!win_valid_q || bus.win_ready) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Window slot: a newly completed window takes priority over consumption.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else if (win_set) begin
      win_valid_q <= 1'b1;
      win_row_q   <= row - COORD_W'(1);
      win_col_q   <= col - COORD_W'(1);
    end else if (win_take) begin
      win_valid_q <= 1'b0;
    end
  end

`ifdef CONV_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  assign stall_cnt = stall_cnt_q;

  // Saturating count of RUN cycles where upstream offered a pixel in vain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (frame_start) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RUN) && bus.pix_valid && !pix_ready &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler on a 5x4 frame.
module tb_conv_window_scheduler;

  localparam int IMG_W   = 5;
  localparam int IMG_H   = 4;
  localparam int ADDR_W  = 16;
  localparam int COORD_W = 9;
  localparam int MAXC    = 128;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;
`ifdef CONV_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks;
  int errors;

  // per-cycle samples of one frame run
  int s_shift [MAXC];
  int s_ready [MAXC];
  int s_addr  [MAXC];
  int s_wv    [MAXC];
  int s_wr    [MAXC];
  int s_row   [MAXC];
  int s_col   [MAXC];
  int s_busy  [MAXC];
  int done_cyc;

  // expected window centres in raster order
  int exp_wrow [6] = '{1, 1, 1, 2, 2, 2};
  int exp_wcol [6] = '{1, 2, 3, 1, 2, 3};

  conv_window_scheduler_if #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) bus ();

  conv_window_scheduler #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .ADDR_W  (ADDR_W),
    .COORD_W (COORD_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
`ifdef CONV_SCHED_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one frame from a start pulse at cycle 0 until done (bounded).
  // valid_mode 1 offers a pixel on even cycles only; stall_n holds win_ready
  // low for that many cycles when the first window shows; restart_cyc pulses
  // start again with pix_valid low in that cycle.
  task automatic run_frame(input int valid_mode, input int stall_n, input int restart_cyc);
    int stall_left;
    bit stall_started;
    stall_left = 0;
    stall_started = 0;
    done_cyc = -1;
    for (int c = 0; c < MAXC; c++) begin
      s_shift[c] = 0; s_ready[c] = 0; s_addr[c] = 0; s_wv[c] = 0;
      s_wr[c] = 0; s_row[c] = 0; s_col[c] = 0; s_busy[c] = 0;
    end
    for (int c = 0; c < MAXC; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == restart_cyc);
      if (valid_mode == 1) bus.pix_valid = (c % 2 == 0);
      else                 bus.pix_valid = (c != restart_cyc);
      if (stall_n > 0 && !stall_started && bus.win_valid) begin
        stall_started = 1;
        stall_left = stall_n;
      end
      if (stall_left > 0) begin
        bus.win_ready = 1'b0;
        stall_left--;
      end else begin
        bus.win_ready = 1'b1;
      end
      @(negedge clk);
      s_shift[c] = int'(bus.lb_shift);
      s_ready[c] = int'(bus.pix_ready);
      s_addr[c]  = int'(bus.pix_addr);
      s_wv[c]    = int'(bus.win_valid);
      s_wr[c]    = int'(bus.win_ready);
      s_row[c]   = int'(bus.win_row);
      s_col[c]   = int'(bus.win_col);
      s_busy[c]  = int'(busy);
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b1;
  endtask

  // Reduces samples: accept count, out-of-order addresses, windows seen,
  // windows with wrong centres.
  task automatic summarize(output int nshift, output int addr_bad,
                           output int nwin, output int win_bad);
    int last;
    nshift = 0; addr_bad = 0; nwin = 0; win_bad = 0;
    last = (done_cyc < 0) ? MAXC - 1 : done_cyc;
    for (int c = 0; c <= last; c++) begin
      if (s_shift[c] != 0) begin
        if (s_addr[c] != nshift) addr_bad++;
        nshift++;
      end
      if (s_wv[c] != 0 && s_wr[c] != 0) begin
        if (nwin >= 6 || s_row[c] != exp_wrow[nwin] || s_col[c] != exp_wcol[nwin]) win_bad++;
        nwin++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    bus.pix_valid = 1'b1;
    bus.win_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, bus.pix_ready, bus.lb_shift, bus.win_valid} !== 5'b0 ||
        bus.pix_addr !== '0 || bus.win_row !== '0 || bus.win_col !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b rdy=%0b shift=%0b wv=%0b addr=%0d row=%0d col=%0d, all required 0",
               busy, done, bus.pix_ready, bus.lb_shift, bus.win_valid, bus.pix_addr, bus.win_row, bus.win_col);
    end
`ifdef CONV_SCHED_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // idle with pix_valid high: nothing accepted
    checks++;
    if (bus.pix_ready !== 1'b0 || bus.lb_shift !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_valid: rdy=%0b shift=%0b busy=%0b expected 0 0 0",
               bus.pix_ready, bus.lb_shift, busy);
    end
    @(posedge clk); #1 bus.pix_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int ns, ab, nw, wb;
    run_frame(0, 0, -1);
    summarize(ns, ab, nw, wb);
    checks++;
    if (ns !== 20) begin errors++; $display("FAIL full_shifts: got %0d expected 20", ns); end
    checks++;
    if (ab !== 0) begin errors++; $display("FAIL full_addr_seq: %0d bad addresses expected 0", ab); end
    checks++;
    if (nw !== 6) begin errors++; $display("FAIL full_windows: got %0d expected 6", nw); end
    checks++;
    if (wb !== 0) begin errors++; $display("FAIL full_centres: %0d wrong centres expected 0", wb); end
    checks++;
    if (done_cyc !== 22) begin errors++; $display("FAIL full_done_cycle: got %0d expected 22", done_cyc); end
    checks++;
    if (done_cyc >= 0 && s_busy[done_cyc] !== 1) begin
      errors++; $display("FAIL full_busy_at_done: got %0d expected 1", s_busy[done_cyc]);
    end
    checks++;
    if (s_ready[0] !== 0 || s_shift[0] !== 0) begin
      errors++; $display("FAIL full_start_cycle: rdy=%0d shift=%0d expected 0 0", s_ready[0], s_shift[0]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.pix_addr !== '0) begin
      errors++;
      $display("FAIL full_after_done: busy=%0b done=%0b addr=%0d expected 0 0 0", busy, done, bus.pix_addr);
    end
`ifdef CONV_SCHED_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL full_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    int ns, ab, nw, wb;
    run_frame(0, 3, -1);
    summarize(ns, ab, nw, wb);
    for (int c = 14; c <= 16; c++) begin
      checks++;
      if (s_ready[c] !== 0 || s_shift[c] !== 0 || s_wv[c] !== 1 || s_row[c] !== 1 || s_col[c] !== 1) begin
        errors++;
        $display("FAIL bp_hold_c%0d: rdy=%0d shift=%0d wv=%0d win=(%0d,%0d) expected 0 0 1 (1,1)",
                 c, s_ready[c], s_shift[c], s_wv[c], s_row[c], s_col[c]);
      end
    end
    checks++;
    if (s_shift[17] !== 1 || s_addr[17] !== 13) begin
      errors++; $display("FAIL bp_resume: shift=%0d addr=%0d expected 1 13", s_shift[17], s_addr[17]);
    end
    checks++;
    if (ns !== 20 || ab !== 0) begin errors++; $display("FAIL bp_shifts: got %0d (bad addr %0d) expected 20 (0)", ns, ab); end
    checks++;
    if (nw !== 6 || wb !== 0) begin errors++; $display("FAIL bp_windows: got %0d (bad %0d) expected 6 (0)", nw, wb); end
    checks++;
    if (done_cyc !== 25) begin errors++; $display("FAIL bp_done_cycle: got %0d expected 25", done_cyc); end
`ifdef CONV_SCHED_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected 3", stall_cnt); end
`endif
  endtask

  task automatic test_toggle_valid();
    int ns, ab, nw, wb;
    run_frame(1, 0, -1);
    summarize(ns, ab, nw, wb);
    checks++;
    if (ns !== 20 || ab !== 0) begin errors++; $display("FAIL tog_shifts: got %0d (bad addr %0d) expected 20 (0)", ns, ab); end
    checks++;
    if (nw !== 6 || wb !== 0) begin errors++; $display("FAIL tog_windows: got %0d (bad %0d) expected 6 (0)", nw, wb); end
    checks++;
    if (s_ready[1] !== 1 || s_shift[1] !== 0 || s_shift[2] !== 1 || s_addr[3] !== 1) begin
      errors++;
      $display("FAIL tog_gap: rdy1=%0d shift1=%0d shift2=%0d addr3=%0d expected 1 0 1 1",
               s_ready[1], s_shift[1], s_shift[2], s_addr[3]);
    end
    checks++;
    if (done_cyc !== 42) begin errors++; $display("FAIL tog_done_cycle: got %0d expected 42", done_cyc); end
`ifdef CONV_SCHED_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL tog_stall_cleared: got %0d expected 0", stall_cnt); end
`endif
  endtask

  task automatic test_start_ignored();
    int ns, ab, nw, wb;
    run_frame(0, 0, 9);
    summarize(ns, ab, nw, wb);
    checks++;
    if (s_shift[9] !== 0 || s_addr[9] !== 8 || s_busy[9] !== 1) begin
      errors++;
      $display("FAIL restart_cycle: shift=%0d addr=%0d busy=%0d expected 0 8 1", s_shift[9], s_addr[9], s_busy[9]);
    end
    checks++;
    if (s_shift[10] !== 1 || s_addr[10] !== 8) begin
      errors++; $display("FAIL restart_continue: shift=%0d addr=%0d expected 1 8", s_shift[10], s_addr[10]);
    end
    checks++;
    if (ns !== 20 || ab !== 0 || nw !== 6 || wb !== 0) begin
      errors++; $display("FAIL restart_frame: shifts=%0d badaddr=%0d wins=%0d badwin=%0d expected 20 0 6 0", ns, ab, nw, wb);
    end
    checks++;
    if (done_cyc !== 23) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 23", done_cyc); end
  endtask

  task automatic test_reset_midframe();
    int ns, ab, nw, wb;
    @(posedge clk); #1;
    start = 1'b1; bus.pix_valid = 1'b1; bus.win_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    checks++;
    if (bus.win_valid !== 1'b1 || busy !== 1'b1 || bus.pix_addr !== 16'd14 || bus.win_col !== 9'd2) begin
      errors++;
      $display("FAIL midframe_pre: wv=%0b busy=%0b addr=%0d col=%0d expected 1 1 14 2",
               bus.win_valid, busy, bus.pix_addr, bus.win_col);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.pix_ready, bus.lb_shift, bus.win_valid} !== 5'b0 ||
        bus.pix_addr !== '0 || bus.win_row !== '0 || bus.win_col !== '0) begin
      errors++;
      $display("FAIL midframe_reset: busy=%0b done=%0b rdy=%0b shift=%0b wv=%0b addr=%0d row=%0d col=%0d, all required 0",
               busy, done, bus.pix_ready, bus.lb_shift, bus.win_valid, bus.pix_addr, bus.win_row, bus.win_col);
    end
    @(posedge clk); #1 reset = 1'b1;
    run_frame(0, 0, -1);
    summarize(ns, ab, nw, wb);
    checks++;
    if (s_shift[1] !== 1 || s_addr[1] !== 0) begin
      errors++; $display("FAIL midframe_restart_addr: shift=%0d addr=%0d expected 1 0", s_shift[1], s_addr[1]);
    end
    checks++;
    if (ns !== 20 || nw !== 6 || done_cyc !== 22) begin
      errors++; $display("FAIL midframe_new_frame: shifts=%0d wins=%0d done=%0d expected 20 6 22", ns, nw, done_cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_toggle_valid();
    test_start_ignored();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
